tt_um_seq_ctrl: RTL
===================

Name: tt_um_seq_ctrl

Overview:
Top-level sequencer for the ternary matrix-vector engine. Generates the 4-bit load count and load enable that drive the weight shift-loader, and gates the compute stage. Serialises the MAX_OUT_LEN per-output results onto the shared 8-bit output pins. Sits between the tile pins (ui_in/uio_in strobes) and the loader/compute datapath.

Parameters:
MAX_IN_LEN, 16, activation vector length (loader input width per cycle)
MAX_OUT_LEN, 8, number of output neurons / results to drain
WIDTH, 2, bits per ternary weight
LOAD_CYCLES, (WIDTH*MAX_OUT_LEN), cycles to fill weight register (16 at defaults)
CNT_BITS, $clog2(LOAD_CYCLES), load counter width (4)
SEL_BITS, $clog2(MAX_OUT_LEN), output-select width (3)

Ports:
clk  input  1  clock
rst_n  input  1  reset_n - low to reset, asynchronous, active-low
ena  input  1  tile enable; low freezes all state
start_load  input  1  request weight (re)load; level sampled on clk
in_valid  input  1  activation vector on ui pins valid this cycle
load_en  output  1  drives loader ena; high only during LOAD
load_count  output  CNT_BITS  drives loader count
load_done  output  1  high on final load beat (load_count == LOAD_CYCLES-1 with load_en)
weights_valid  output  1  weight register holds a complete load
compute_en  output  1  one-cycle strobe: latch activations into compute stage
out_valid  output  1  result for out_sel is on output pins
out_sel  output  SEL_BITS  output neuron index being presented
busy  output  1  state is not IDLE or READY

Behaviour:
- Reset (async, rst_n=0): state=IDLE; load_count=0, out_sel=0; load_en, load_done, compute_en, out_valid, weights_valid, busy, pending_load all 0.
- States: IDLE, LOAD, READY, COMPUTE, DRAIN. All transitions on posedge clk, only when ena=1.
- IDLE: start_load=1 -> LOAD, load_count=0. in_valid ignored.
- LOAD: load_en=1; load_count increments by 1 each cycle, 0..LOAD_CYCLES-1. load_done=1 combinationally at count LOAD_CYCLES-1. Next edge -> READY, weights_valid=1, load_count wraps to 0. start_load/in_valid ignored in LOAD. weights_valid cleared on entry to LOAD.
- READY: start_load has priority over in_valid if both high -> LOAD. in_valid=1 -> COMPUTE.
- COMPUTE: exactly one cycle; compute_en=1. -> DRAIN, out_sel=0.
- DRAIN: out_valid=1 for MAX_OUT_LEN cycles, out_sel 0..MAX_OUT_LEN-1. After out_sel=MAX_OUT_LEN-1: -> LOAD if pending_load, else READY; out_sel returns to 0.
- start_load seen in COMPUTE or DRAIN sets pending_load; cleared on entry to LOAD.
- in_valid in COMPUTE/DRAIN dropped (no queueing).
- Latency: in_valid at edge k -> compute_en during cycle k+1 -> first out_valid cycle k+2 -> last out_valid cycle k+1+MAX_OUT_LEN.
- Load latency: start_load at edge k -> load_en cycles k+1..k+LOAD_CYCLES -> weights_valid from k+LOAD_CYCLES+1.
- ena=0: state, counters and pending_load hold. load_en, compute_en and out_valid forced 0 while ena=0. The sequence resumes where it stopped when ena returns high.
- rst_n asserted mid-LOAD or mid-DRAIN: immediate return to IDLE, partial weights invalid.

Optional Feature:
SEQ_ERR_FLAG_EN:
- Defined: adds output err_sticky (1 bit, reset 0). Set on any of: in_valid in IDLE, LOAD, COMPUTE or DRAIN; start_load during LOAD. Cleared only by rst_n.
- Not defined: port absent; those events silently ignored as above.

Test Plan:
- Reset then start_load pulse at edge 0 -> load_en high cycles 1..16, load_count 0..15, load_done only at count 15, weights_valid=1 from cycle 17, state READY.
- In READY, in_valid at edge k -> compute_en single cycle k+1; out_valid k+2..k+9 with out_sel 0..7; then READY, out_valid=0.
- start_load and in_valid both high in READY -> LOAD entered, no compute_en, weights_valid drops to 0.
- start_load at out_sel=3 during DRAIN -> drain completes through out_sel=7, then LOAD immediately, no READY cycle.
- ena low for 5 cycles at load_count=6 -> load_en=0 and count held at 6; after ena high, counting resumes 6..15 and total load beats = 16.
- rst_n low at out_sel=4 -> all outputs 0 asynchronously. With SEQ_ERR_FLAG_EN: in_valid during LOAD -> err_sticky=1, held until reset.

Source files
------------

// File: rtl/tt_um_seq_ctrl.sv
// Sequencer for the ternary matrix-vector engine: weight load, compute strobe and result drain.
// Define SEQ_ERR_FLAG_EN to add the err_sticky protocol-violation flag.
module tt_um_seq_ctrl #(
    parameter int unsigned MAX_IN_LEN  = 16,
    parameter int unsigned MAX_OUT_LEN = 8,
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned LOAD_CYCLES = WIDTH * MAX_OUT_LEN,
    parameter int unsigned CNT_BITS    = $clog2(LOAD_CYCLES),
    parameter int unsigned SEL_BITS    = $clog2(MAX_OUT_LEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                start_load,
    input  logic                in_valid,
    output logic                load_en,
    output logic [CNT_BITS-1:0] load_count,
    output logic                load_done,
    output logic                weights_valid,
    output logic                compute_en,
    output logic                out_valid,
    output logic [SEL_BITS-1:0] out_sel,
`ifdef SEQ_ERR_FLAG_EN
    output logic                err_sticky,
`endif
    output logic                busy
);

    localparam logic [CNT_BITS-1:0] LastCnt = CNT_BITS'(LOAD_CYCLES - 1);
    localparam logic [SEL_BITS-1:0] LastSel = SEL_BITS'(MAX_OUT_LEN - 1);

    if (MAX_IN_LEN == 0 || MAX_OUT_LEN < 2 || LOAD_CYCLES < 2) begin : gen_bad_params
        $error("tt_um_seq_ctrl: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StReady,
        StCompute,
        StDrain
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [SEL_BITS-1:0] sel_q, sel_d;
    logic                wv_q, wv_d;
    logic                pend_q, pend_d;
    logic                go_load;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        wv_d    = wv_q;
        pend_d  = pend_q;
        go_load = 1'b0;
        if (ena) begin
            unique case (state_q)
                StIdle: go_load = start_load;
                StLoad: begin
                    if (cnt_q == LastCnt) begin
                        state_d = StReady;
                        cnt_d   = '0;
                        wv_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
                StReady: begin
                    if (start_load) begin
                        go_load = 1'b1;
                    end else if (in_valid) begin
                        state_d = StCompute;
                    end
                end
                StCompute: begin
                    state_d = StDrain;
                    sel_d   = '0;
                    if (start_load) pend_d = 1'b1;
                end
                StDrain: begin
                    if (start_load) pend_d = 1'b1;
                    if (sel_q == LastSel) begin
                        sel_d = '0;
                        // A request arriving on the final beat still counts as pending.
                        if (pend_q || start_load) begin
                            go_load = 1'b1;
                        end else begin
                            state_d = StReady;
                        end
                    end else begin
                        sel_d = sel_q + SEL_BITS'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (go_load) begin
            state_d = StLoad;
            cnt_d   = '0;
            wv_d    = 1'b0;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= '0;
            wv_q    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            wv_q    <= wv_d;
            pend_q  <= pend_d;
        end
    end

    // Strobes are gated by ena so a frozen tile never shifts or latches.
    always_comb begin
        load_en       = ena && (state_q == StLoad);
        load_done     = load_en && (cnt_q == LastCnt);
        compute_en    = ena && (state_q == StCompute);
        out_valid     = ena && (state_q == StDrain);
        busy          = (state_q != StIdle) && (state_q != StReady);
        load_count    = cnt_q;
        out_sel       = sel_q;
        weights_valid = wv_q;
    end

`ifdef SEQ_ERR_FLAG_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (ena) begin
            if (in_valid && (state_q != StReady)) err_d = 1'b1;
            if (start_load && (state_q == StLoad)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sticky = err_q;
`endif

endmodule
